// File: rtl/ahb_fetch_master.sv
// rtl/ahb_fetch_master.sv - AHB instruction-fetch master with credit-limited response FIFO
module ahb_fetch_master #(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_haddr;
  logic [1:0]        r_htrans;
  logic              r_drop;

  logic [31:0]       r_fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic              r_fifo_err  [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_inflight;
  logic [CNT_W:0]    w_occupancy;
  logic              w_credit_ok;
  logic              w_accept;
  logic              w_misaligned;
  logic              w_data_done;
  logic              w_push_bus;
  logic              w_push_mis;
  logic              w_push;
  logic              w_pop;
  logic [31:0]       w_push_data;
  logic [ADDR_W-1:0] w_push_addr;
  logic              w_push_err;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit counts the outstanding bus fetch so every response is guaranteed a FIFO slot.
  assign w_inflight   = (r_state != S_IDLE);
  assign w_occupancy  = {1'b0, r_count} + (CNT_W + 1)'(w_inflight);
  assign w_credit_ok  = w_occupancy < (CNT_W + 1)'(FIFO_DEPTH);
  assign req_ready    = HRESETn && (r_state == S_IDLE) && w_credit_ok && !flush;
  assign w_accept     = req_valid && req_ready;
  assign w_misaligned = (req_addr[1:0] != 2'b00);
  assign w_data_done  = (r_state == S_DATA) && HREADY;

  assign w_push_bus  = w_data_done && !r_drop && !flush;
  assign w_push_mis  = w_accept && w_misaligned;
  assign w_push      = w_push_bus || w_push_mis;
  assign w_push_data = w_push_bus ? HRDATA : 32'h0;
  assign w_push_addr = w_push_bus ? r_haddr : req_addr;
  assign w_push_err  = w_push_bus ? (HRESP != 2'b00) : 1'b1;

  assign rsp_valid = (r_count != '0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign rsp_data  = r_fifo_data[r_rd_ptr];
  assign rsp_addr  = r_fifo_addr[r_rd_ptr];
  assign rsp_err   = r_fifo_err[r_rd_ptr];

  assign HADDR  = r_haddr;
  assign HTRANS = r_htrans;
  assign HWRITE = 1'b0;
  assign HSIZE  = 3'b010;
  assign HWDATA = 32'h0;
  assign busy   = (r_state != S_IDLE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= S_IDLE;
      r_haddr  <= '0;
      r_htrans <= 2'b00;
      r_drop   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_misaligned) begin
            r_haddr  <= req_addr;
            r_htrans <= 2'b10;
            r_state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (flush) r_drop <= 1'b1;
          if (HREADY) begin
            r_htrans <= 2'b00;
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          // A flush on the completion edge is handled by suppressing the push instead.
          if (HREADY) begin
            r_drop  <= 1'b0;
            r_state <= S_IDLE;
          end else if (flush) begin
            r_drop <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_htrans <= 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_addr[i] <= '0;
        r_fifo_err[i]  <= 1'b0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_push_data;
        r_fifo_addr[r_wr_ptr] <= w_push_addr;
        r_fifo_err[r_wr_ptr]  <= w_push_err;
        r_wr_ptr              <= next_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_fetch_master.sv
// tb/tb_ahb_fetch_master.sv - directed bench for ahb_fetch_master with a small AHB memory slave
module tb_ahb_fetch_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic        busy;

  int          n_checks = 0;
  int          n_fail = 0;

  int          wait_states;
  logic        hold_low;
  logic [31:0] err_addr;
  int          nonseq_cnt = 0;
  int          pop_cnt = 0;
  logic        s_dph;
  int          s_wait;
  logic [31:0] s_addr;
  logic [31:0] mem [16];

  ahb_fetch_master #(.FIFO_DEPTH(2), .ADDR_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  // Memory slave: wait_states low cycles in the data phase; hold_low stretches the address phase.
  assign HREADY = hold_low ? 1'b0 : (s_dph ? (s_wait == 0) : 1'b1);
  assign HRDATA = s_dph ? mem[s_addr[5:2]] : 32'h0;
  assign HRESP  = (s_dph && s_wait == 0 && s_addr == err_addr) ? 2'b01 : 2'b00;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_dph  <= 1'b0;
      s_wait <= 0;
      s_addr <= 32'h0;
    end else if (HREADY) begin
      if (HTRANS == 2'b10) begin
        s_dph      <= 1'b1;
        s_addr     <= HADDR;
        s_wait     <= wait_states;
        nonseq_cnt <= nonseq_cnt + 1;
      end else begin
        s_dph <= 1'b0;
      end
    end else if (s_dph && s_wait > 0) begin
      s_wait <= s_wait - 1;
    end
  end

  always @(posedge HCLK) begin
    if (rsp_valid && rsp_ready) pop_cnt <= pop_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_req(input logic [31:0] a, input int max, output bit acc);
    bit rdy;
    acc = 1'b0;
    req_valid = 1'b1;
    req_addr = a;
    for (int i = 0; i < max; i++) begin
      #1;
      rdy = req_ready;
      @(posedge HCLK);
      #1;
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (rsp_valid) break;
      step();
    end
    check_eq(tag, rsp_valid, 1);
  endtask

  task automatic pop();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit blocked;
    int lat;
    int n0;
    int p0;

    req_valid = 1'b0;
    req_addr = 32'h0;
    flush = 1'b0;
    rsp_ready = 1'b0;
    wait_states = 0;
    hold_low = 1'b0;
    err_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    mem[2] = 32'h00F0_0193;
    mem[3] = 32'h0140_0213;
    mem[4] = 32'h0190_0293;
    mem[8] = 32'hDEAD_BEEF;

    repeat (3) @(posedge HCLK);
    #1;
    check_eq("rst_htrans", HTRANS, 2'b00);
    check_eq("rst_haddr", HADDR, 32'h0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 32'h0);
    check_eq("rst_rsp_addr", rsp_addr, 32'h0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("const_hwrite", HWRITE, 0);
    check_eq("const_hsize", HSIZE, 3'b010);
    check_eq("const_hwdata", HWDATA, 32'h0);
    HRESETn = 1'b1;
    step();

    // single fetch, two-cycle data phase
    wait_states = 1;
    do_req(32'h0, 10, acc);
    check_eq("t1_accept", acc, 1);
    check_eq("t1_htrans_nonseq", HTRANS, 2'b10);
    check_eq("t1_haddr", HADDR, 32'h0);
    check_eq("t1_busy", busy, 1);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    check_eq("t1_latency", lat, 3);
    check_eq("t1_data", rsp_data, 32'h0050_0093);
    check_eq("t1_addr", rsp_addr, 32'h0);
    check_eq("t1_err", rsp_err, 0);
    check_eq("t1_nonseq_count", nonseq_cnt, 1);
    check_eq("t1_htrans_idle", HTRANS, 2'b00);
    pop();
    check_eq("t1_empty", rsp_valid, 0);

    // back-to-back fetches against a full FIFO
    wait_states = 0;
    do_req(32'h0, 10, acc);
    do_req(32'h4, 10, acc);
    check_eq("t2_accept_4", acc, 1);
    repeat (4) step();
    check_eq("t2_nonseq_count", nonseq_cnt, 3);
    check_eq("t2_head_addr0", rsp_addr, 32'h0);
    req_valid = 1'b1;
    req_addr = 32'h8;
    blocked = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (req_ready) blocked = 1'b0;
      step();
    end
    check_eq("t2_blocked_while_full", blocked, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    check_eq("t2_ready_after_pop", req_ready, 1);
    @(posedge HCLK);
    #1;
    req_valid = 1'b0;
    check_eq("t2_head_addr4", rsp_addr, 32'h4);
    repeat (3) step();
    check_eq("t2_data4", rsp_data, 32'h00A0_0113);
    pop();
    check_eq("t2_head_addr8", rsp_addr, 32'h8);
    check_eq("t2_data8", rsp_data, 32'h00F0_0193);
    pop();
    check_eq("t2_empty", rsp_valid, 0);

    // flush while the address phase is stalled
    hold_low = 1'b1;
    do_req(32'hC, 10, acc);
    check_eq("t3_accept", acc, 1);
    check_eq("t3_htrans_a", HTRANS, 2'b10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("t3_htrans_b", HTRANS, 2'b10);
    check_eq("t3_haddr_b", HADDR, 32'hC);
    step();
    check_eq("t3_htrans_c", HTRANS, 2'b10);
    hold_low = 1'b0;
    repeat (4) step();
    check_eq("t3_dropped", rsp_valid, 0);
    check_eq("t3_idle", busy, 0);
    check_eq("t3_nonseq_count", nonseq_cnt, 5);
    do_req(32'h10, 10, acc);
    wait_rsp("t3_rsp_10", 10);
    check_eq("t3_addr10", rsp_addr, 32'h10);
    check_eq("t3_data10", rsp_data, 32'h0190_0293);
    pop();

    // flush on the data completion edge, next fetch must not be dropped
    do_req(32'h4, 10, acc);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (2) step();
    check_eq("t3b_dropped", rsp_valid, 0);
    do_req(32'h8, 10, acc);
    wait_rsp("t3b_rsp_8", 10);
    check_eq("t3b_data8", rsp_data, 32'h00F0_0193);
    pop();

    // flush with full FIFO and same-cycle pop
    do_req(32'h0, 10, acc);
    do_req(32'h4, 10, acc);
    repeat (3) step();
    check_eq("t4_full_ready", req_ready, 0);
    p0 = pop_cnt;
    flush = 1'b1;
    rsp_ready = 1'b1;
    step();
    flush = 1'b0;
    rsp_ready = 1'b0;
    check_eq("t4_empty", rsp_valid, 0);
    step();
    check_eq("t4_pops", pop_cnt - p0, 1);
    check_eq("t4_ready", req_ready, 1);

    // misaligned request and bus error
    n0 = nonseq_cnt;
    do_req(32'h6, 10, acc);
    check_eq("t5_mis_valid", rsp_valid, 1);
    check_eq("t5_mis_err", rsp_err, 1);
    check_eq("t5_mis_addr", rsp_addr, 32'h6);
    check_eq("t5_mis_data", rsp_data, 32'h0);
    check_eq("t5_mis_busy", busy, 0);
    step();
    check_eq("t5_no_bus", nonseq_cnt - n0, 0);
    pop();
    err_addr = 32'h20;
    do_req(32'h20, 10, acc);
    wait_rsp("t5_rsp_20", 10);
    check_eq("t5_bus_err", rsp_err, 1);
    check_eq("t5_bus_addr", rsp_addr, 32'h20);
    check_eq("t5_bus_data", rsp_data, 32'hDEAD_BEEF);
    pop();
    err_addr = 32'hFFFF_FFFF;

    // asynchronous reset in the data phase
    wait_states = 2;
    do_req(32'h4, 10, acc);
    step();
    check_eq("t6_busy", busy, 1);
    #2;
    HRESETn = 1'b0;
    #1;
    check_eq("t6_busy_rst", busy, 0);
    check_eq("t6_htrans_rst", HTRANS, 2'b00);
    check_eq("t6_haddr_rst", HADDR, 32'h0);
    check_eq("t6_valid_rst", rsp_valid, 0);
    check_eq("t6_ready_rst", req_ready, 0);
    step();
    HRESETn = 1'b1;
    wait_states = 0;
    repeat (3) step();
    check_eq("t6_no_ghost", rsp_valid, 0);
    do_req(32'h0, 10, acc);
    wait_rsp("t6_rsp_0", 10);
    check_eq("t6_data", rsp_data, 32'h0050_0093);
    check_eq("t6_err", rsp_err, 0);
    pop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
